axis_packet_rr_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one AXIS processor input stream among NUM_INP requesting AXIS sources. Sits directly upstream of the processor slave port: selects one source, holds the grant until that source's `tlast` beat is accepted, then rotates priority. Data path is an unregistered mux; only arbitration state is registered.

---
 rtl/axis_packet_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_axis_packet_rr_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_rr_arbiter.sv
// Packet-granular round-robin arbiter: one of NUM_INP AXIS sources owns the output until its tlast beat is accepted.
// Latency: one arbitration cycle from request to first beat, one idle bubble after every packet; data path is a pure mux.
// Backpressure: m_tready passes combinationally to the granted source only; all other sources see s_tready=0.
// Optional: define AXIS_ARB_TID_EN to add the m_tid output carrying the granted source index.
module axis_packet_rr_arbiter #(
    parameter int NUM_INP           = 4,
    parameter int TDATA_WIDTH_BYTES = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_INP-1:0]                   s_tvalid,
    output logic [NUM_INP-1:0]                   s_tready,
    input  logic [NUM_INP*TDATA_WIDTH_BYTES*8-1:0] s_tdata,
    input  logic [NUM_INP*TDATA_WIDTH_BYTES-1:0] s_tkeep,
    input  logic [NUM_INP-1:0]                   s_tlast,
    output logic                                 m_tvalid,
    input  logic                                 m_tready,
    output logic [TDATA_WIDTH_BYTES*8-1:0]       m_tdata,
    output logic [TDATA_WIDTH_BYTES-1:0]         m_tkeep,
    output logic                                 m_tlast,
`ifdef AXIS_ARB_TID_EN
    output logic [$clog2(NUM_INP)-1:0]           m_tid,
`endif
    output logic [NUM_INP-1:0]                   grant,
    output logic                                 busy
);

    localparam int IDX_W = $clog2(NUM_INP);
    localparam int DW    = TDATA_WIDTH_BYTES * 8;
    localparam logic [IDX_W:0]   NUM_W    = (IDX_W+1)'(NUM_INP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INP - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     gnt_idx;
    logic [NUM_INP-1:0]   grant_q;
    logic                 busy_q;

    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W:0]       cand;
    logic                 locked;
    logic                 xfer_last;

    assign locked = (state == LOCKED);

    // Round-robin pick: scan offsets from ptr downward so the smallest offset (closest to ptr) wins last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NUM_INP - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (s_tvalid[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    // The packet ends only when the granted source's tlast beat is actually accepted.
    assign xfer_last = locked & s_tvalid[gnt_idx] & m_tready & s_tlast[gnt_idx];

    // Arbitration FSM: lock onto the picked source, release and advance ptr past it on the accepted tlast.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_idx <= pick_idx;
                        grant_q <= NUM_INP'(1) << pick_idx;
                        busy_q  <= 1'b1;
                        state   <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer_last) begin
                        ptr     <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ready is steered only to the owner; every other source is held off for the whole packet.
    always_comb begin
        s_tready = '0;
        if (locked) begin
            s_tready[gnt_idx] = m_tready;
        end
    end

    // Data mux always follows the owner; valid and last are qualified so nothing leaks out while idle.
    assign m_tvalid = locked & s_tvalid[gnt_idx];
    assign m_tlast  = locked & s_tlast[gnt_idx];
    assign m_tdata  = s_tdata[gnt_idx*DW +: DW];
    assign m_tkeep  = s_tkeep[gnt_idx*TDATA_WIDTH_BYTES +: TDATA_WIDTH_BYTES];
    assign grant    = grant_q;
    assign busy     = busy_q;

`ifdef AXIS_ARB_TID_EN
    // Source tag for the downstream processor; zero whenever no packet is locked.
    assign m_tid = locked ? gnt_idx : '0;
`endif

endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// Bench for axis_packet_rr_arbiter: queued source models feed the DUT, a scoreboard checks every accepted beat.
// Beats are compared in order against hand-ordered expectations; per-cycle invariants cover idle outputs and grant stability.
// Source queues pop only on an observed s_tvalid & s_tready handshake.
module tb_axis_packet_rr_arbiter;

    localparam int N  = 4;
    localparam int KB = 4;
    localparam int DW = KB * 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      s_tvalid = '0;
    logic [N-1:0]      s_tready;
    logic [N*DW-1:0]   s_tdata = '0;
    logic [N*KB-1:0]   s_tkeep = '0;
    logic [N-1:0]      s_tlast = '0;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic [DW-1:0]     m_tdata;
    logic [KB-1:0]     m_tkeep;
    logic              m_tlast;
    logic [N-1:0]      grant;
    logic              busy;
`ifdef AXIS_ARB_TID_EN
    logic [1:0]        m_tid;
`endif

    axis_packet_rr_arbiter #(.NUM_INP(N), .TDATA_WIDTH_BYTES(KB)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast),
`ifdef AXIS_ARB_TID_EN
        .m_tid(m_tid),
`endif
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KB-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [1:0] src;
        beat_t      b;
    } exp_t;

    beat_t        src_q[N][$];
    exp_t         exp_q[$];
    logic [N-1:0] src_en = '1;
    logic [N-1:0] fired  = '0;
    bit           mon_on = 1'b0;
    int           n_chk  = 0;
    int           n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    function automatic beat_t mk(input int s, input int p, input int b, input int len);
        beat_t r;
        r.data = 32'hD000_0000 | 32'(s << 8) | 32'(p << 4) | 32'(b);
        r.last = (b == len - 1);
        r.keep = r.last ? 4'b0111 : 4'hF;
        return r;
    endfunction

    task automatic src_push(input int s, input int p, input int len);
        for (int b = 0; b < len; b++) src_q[s].push_back(mk(s, p, b, len));
    endtask

    task automatic exp_push(input int s, input int p, input int first, input int last_b, input int len);
        exp_t e;
        for (int b = first; b <= last_b; b++) begin
            e.src = 2'(s);
            e.b   = mk(s, p, b, len);
            exp_q.push_back(e);
        end
    endtask

    function automatic int pending();
        int t = exp_q.size();
        for (int i = 0; i < N; i++) t += src_q[i].size();
        return t;
    endfunction

    task automatic wait_drain();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk); #4;
            if (pending() == 0) break;
        end
        chk("drain_remaining", 64'(pending()), 0);
    endtask

    // Source models: present queue heads after the falling edge, retire beats that handshook at the rising edge.
    initial begin
        forever begin
            @(negedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0) begin
                    s_tvalid[i]             = src_en[i];
                    s_tdata[i*DW +: DW]     = src_q[i][0].data;
                    s_tkeep[i*KB +: KB]     = src_q[i][0].keep;
                    s_tlast[i]              = src_q[i][0].last;
                end else begin
                    s_tvalid[i]             = 1'b0;
                    s_tdata[i*DW +: DW]     = '0;
                    s_tkeep[i*KB +: KB]     = '0;
                    s_tlast[i]              = 1'b0;
                end
            end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            fired = '0;
        end
    end

    // Monitor: score each accepted output beat and check per-cycle arbitration invariants.
    initial begin
        exp_t         e;
        logic         prev_busy = 1'b0;
        logic         prev_last = 1'b0;
        logic [N-1:0] prev_grant = '0;
        forever begin
            @(negedge clk); #3;
            if (mon_on && !rst) begin
                fired = s_tvalid & s_tready;
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(m_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", m_tdata, e.b.data);
                        chk("beat_keep", m_tkeep, e.b.keep);
                        chk("beat_last", m_tlast, e.b.last);
                        chk("beat_grant", grant, 4'(1) << e.src);
`ifdef AXIS_ARB_TID_EN
                        chk("beat_tid", m_tid, e.src);
`endif
                    end
                end
                chk("ready_outside_grant", s_tready & ~grant, 0);
                if (!busy) begin
                    chk("idle_outputs", {m_tvalid, s_tready, grant, m_tlast}, 0);
`ifdef AXIS_ARB_TID_EN
                    chk("idle_tid", m_tid, 0);
`endif
                end
                if (prev_busy && busy) chk("grant_stable", grant, prev_grant);
                if (prev_last) chk("bubble_after_last", busy, 0);
                prev_busy  = busy;
                prev_grant = grant;
                prev_last  = m_tvalid & m_tready & m_tlast;
            end else begin
                prev_busy = 1'b0;
                prev_last = 1'b0;
                fired     = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d pending items, required 0", pending());
        $fatal(1, "watchdog");
    end

    // Directed test sequence.
    initial begin
        bit rdy_tab[8] = '{1, 0, 0, 1, 1, 1, 0, 1};
        bit en_tab[8]  = '{1, 1, 1, 0, 0, 1, 1, 1};
        bit seen;

        // Reset held with every source requesting; order after release must be 0,1,2,3.
        for (int s = 0; s < N; s++) begin
            src_push(s, 0, 1);
            exp_push(s, 0, 0, 0, 1);
        end
        repeat (3) begin
            @(posedge clk); #2;
            chk("rst_m_tvalid", m_tvalid, 0);
            chk("rst_s_tready", s_tready, 0);
            chk("rst_grant", grant, 0);
            chk("rst_busy", busy, 0);
            chk("rst_m_tlast", m_tlast, 0);
        end
        @(negedge clk);
        rst    = 1'b0;
        mon_on = 1'b1;
        @(negedge clk); #4;
        chk("first_grant_after_rst", grant, 4'b0001);
        wait_drain();

        // Single requester: source 2, three beats, back to back, then a bubble.
        @(negedge clk);
        src_q[2].push_back(beat_t'{32'hA0, 4'hF, 1'b0});
        src_q[2].push_back(beat_t'{32'hA1, 4'hF, 1'b0});
        src_q[2].push_back(beat_t'{32'hA2, 4'h3, 1'b1});
        exp_q.push_back(exp_t'{2'd2, beat_t'{32'hA0, 4'hF, 1'b0}});
        exp_q.push_back(exp_t'{2'd2, beat_t'{32'hA1, 4'hF, 1'b0}});
        exp_q.push_back(exp_t'{2'd2, beat_t'{32'hA2, 4'h3, 1'b1}});
        @(negedge clk); #4;
        chk("single_grant", grant, 4'b0100);
        chk("single_beat0_valid", m_tvalid, 1);
        @(negedge clk); #4;
        chk("single_beat1_valid", m_tvalid, 1);
        @(negedge clk); #4;
        chk("single_beat2_last", {m_tvalid, m_tlast}, 2'b11);
        @(negedge clk); #4;
        chk("single_bubble_busy", busy, 0);
        wait_drain();

        // All four sources with two 2-beat packets each; ptr is 3 here so order is 3,0,1,2,3,0,1,2.
        @(negedge clk);
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < N; s++) src_push(s, p + 1, 2);
        for (int p = 0; p < 2; p++) begin
            exp_push(3, p + 1, 0, 1, 2);
            exp_push(0, p + 1, 0, 1, 2);
            exp_push(1, p + 1, 0, 1, 2);
            exp_push(2, p + 1, 0, 1, 2);
        end
        wait_drain();

        // Backpressure and source stalls on a 4-beat packet from source 1 while source 2 waits.
        @(negedge clk);
        src_push(1, 4, 4);
        src_push(2, 4, 1);
        exp_push(1, 4, 0, 3, 4);
        exp_push(2, 4, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            m_tready  = rdy_tab[k];
            src_en[1] = en_tab[k];
        end
        @(negedge clk);
        m_tready = 1'b1;
        src_en   = '1;
        wait_drain();

        // Move ptr to 1, then reset in the middle of a source-1 packet.
        @(negedge clk);
        src_push(0, 5, 1);
        exp_push(0, 5, 0, 0, 1);
        wait_drain();
        @(negedge clk);
        src_push(1, 6, 4);
        exp_push(1, 6, 0, 0, 4);
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); #4;
            if (m_tvalid && m_tready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("midrst_beat0_seen", seen, 1);
        @(negedge clk);
        rst      = 1'b1;
        m_tready = 1'b0;
        src_push(0, 7, 1);
        @(negedge clk); #4;
        chk("midrst_busy", busy, 0);
        chk("midrst_grant", grant, 0);
        chk("midrst_m_tvalid", m_tvalid, 0);
        rst      = 1'b0;
        m_tready = 1'b1;
        exp_push(0, 7, 0, 0, 1);
        exp_push(1, 6, 1, 3, 4);
        @(negedge clk); #4;
        chk("post_rst_grant", grant, 4'b0001);
        wait_drain();

        // Source 3 packet; with the tag enabled every beat carries 3 and idle shows 0.
        @(negedge clk);
        src_push(3, 8, 2);
        exp_push(3, 8, 0, 1, 2);
        wait_drain();
        chk("final_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
